// File: rtl/hamming_pkg.sv
// Shared widths, controller state type and the codeword position map
// for the Hamming(11,7) transmit path.
package hamming_pkg;

  localparam int MSG_W = 7;
  localparam int PAR_W = 4;
  localparam int CW_W  = 11;
  localparam int POS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic       is_par;
    logic [2:0] sel;
  } cw_src_t;

  // Position 1..11 -> parity bit Pn (sel = n-1) or message bit m_sel.
  function automatic cw_src_t cw_pos_src(input logic [POS_W-1:0] pos);
    cw_src_t src;
    src = '{is_par: 1'b0, sel: 3'd0};
    case (pos)
      4'd1:    src = '{is_par: 1'b1, sel: 3'd0};
      4'd2:    src = '{is_par: 1'b1, sel: 3'd1};
      4'd3:    src = '{is_par: 1'b0, sel: 3'd0};
      4'd4:    src = '{is_par: 1'b1, sel: 3'd2};
      4'd5:    src = '{is_par: 1'b0, sel: 3'd1};
      4'd6:    src = '{is_par: 1'b0, sel: 3'd2};
      4'd7:    src = '{is_par: 1'b0, sel: 3'd3};
      4'd8:    src = '{is_par: 1'b1, sel: 3'd3};
      4'd9:    src = '{is_par: 1'b0, sel: 3'd4};
      4'd10:   src = '{is_par: 1'b0, sel: 3'd5};
      4'd11:   src = '{is_par: 1'b0, sel: 3'd6};
      default: src = '{is_par: 1'b0, sel: 3'd0};
    endcase
    return src;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational parity generator: 7-bit message in, P1..P4 out (par_o[0] = P1).
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0] msg_i,
  output logic [PAR_W-1:0] par_o
);

  assign par_o[0] = msg_i[0] ^ msg_i[1] ^ msg_i[3] ^ msg_i[4] ^ msg_i[6];
  assign par_o[1] = msg_i[0] ^ msg_i[2] ^ msg_i[3] ^ msg_i[5] ^ msg_i[6];
  assign par_o[2] = msg_i[1] ^ msg_i[2] ^ msg_i[3];
  assign par_o[3] = msg_i[4] ^ msg_i[5] ^ msg_i[6];

endmodule

// File: rtl/hamming_tx_ctrl.sv
// Frame sequencer: accepts a 7-bit message, builds the (optionally corrupted)
// 11-bit codeword and streams it LSB position first over a valid/ready link.
module hamming_tx_ctrl
  import hamming_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg,
  output logic             msg_ready,
  input  logic [POS_W-1:0] err_pos,
  output logic             tx_bit,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_first,
  output logic             tx_last,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [POS_W-1:0] IDX_FIRST = POS_W'(1);
  localparam logic [POS_W-1:0] IDX_LAST  = POS_W'(CW_W);

  tx_state_t        state_q, state_d;
  logic [POS_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAR_W-1:0] par;
  logic [CW_W-1:0]  cw_clean;
  logic [CW_W-1:0]  inj_mask;

  hamming_parity_gen u_parity_gen (
    .msg_i (msg),
    .par_o (par)
  );

  // Bit gi of the codeword vectors holds codeword position gi+1.
  generate
    for (genvar gi = 0; gi < CW_W; gi++) begin : g_cw
      localparam cw_src_t SRC = cw_pos_src(POS_W'(gi + 1));
      if (SRC.is_par) begin : g_par
        assign cw_clean[gi] = par[SRC.sel[1:0]];
      end else begin : g_msg
        assign cw_clean[gi] = msg[SRC.sel];
      end
      assign inj_mask[gi] = (err_pos == POS_W'(gi + 1));
    end
  endgenerate

  assign msg_ready = (state_q == IDLE);
  assign tx_valid  = (state_q == SHIFT);
  assign tx_bit    = tx_valid & cw_q[idx_q - IDX_FIRST];
  assign tx_first  = tx_valid && (idx_q == IDX_FIRST);
  assign tx_last   = tx_valid && (idx_q == IDX_LAST);
  assign frame_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          // Injection happens after parity, so the error is a real channel-style flip.
          cw_d    = cw_clean ^ inj_mask;
          idx_d   = IDX_FIRST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tx_ready) begin
          if (idx_q == IDX_LAST) begin
            cnt_d   = cnt_q + CNT_W'(1);
            idx_d   = IDX_FIRST;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_d = idx_q + POS_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_FIRST;
      gap_q   <= '0;
      cw_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Directed bench: hand-computed codewords, backpressure, mid-frame reset,
// gap length and back-to-back frame counter wrap.
module tb_hamming_tx_ctrl;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       msg_valid = 1'b0;
  logic [6:0] msg = '0;
  logic [3:0] err_pos = '0;
  logic       tx_ready = 1'b1;
  logic       msg_ready, tx_bit, tx_valid, tx_first, tx_last;
  logic [7:0] frame_cnt;

  logic       msg_valid0 = 1'b0;
  logic [6:0] msg0 = 7'h01;
  logic [3:0] err_pos0 = '0;
  logic       tx_ready0 = 1'b1;
  logic       msg_ready0, tx_bit0, tx_valid0, tx_first0, tx_last0;
  logic [7:0] frame_cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  hamming_tx_ctrl #(.GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg(msg), .msg_ready(msg_ready),
    .err_pos(err_pos), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_first(tx_first), .tx_last(tx_last), .frame_cnt(frame_cnt)
  );

  hamming_tx_ctrl #(.GAP_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid0), .msg(msg0), .msg_ready(msg_ready0),
    .err_pos(err_pos0), .tx_bit(tx_bit0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_first(tx_first0), .tx_last(tx_last0), .frame_cnt(frame_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE. exp_bits lists positions 1..11 left to right.
  task automatic send_frame(input logic [6:0] m, input logic [3:0] e, input logic [10:0] exp_bits,
                            input int stall_beat, input int stall_len);
    int beat, stall, cyc, gap;
    check("msg_ready_idle", msg_ready, 1'b1);
    msg_valid = 1'b1;
    msg       = m;
    err_pos   = e;
    tx_ready  = 1'b1;
    beat = 1; stall = 0; cyc = 0;
    while (beat <= 11 && cyc <= 60) begin
      @(negedge clk);
      msg_valid = 1'b0;
      cyc++;
      check($sformatf("tx_valid[%0d]", beat), tx_valid, 1'b1);
      check($sformatf("tx_bit[%0d]", beat), tx_bit, exp_bits[11 - beat]);
      check($sformatf("tx_first[%0d]", beat), tx_first, beat == 1);
      check($sformatf("tx_last[%0d]", beat), tx_last, beat == 11);
      check("msg_ready_shift", msg_ready, 1'b0);
      if (beat == stall_beat && stall < stall_len) begin
        tx_ready = 1'b0;
        stall++;
      end else begin
        tx_ready = 1'b1;
        if (beat == 11) check("frame_cnt_before", frame_cnt, exp_cnt);
        beat++;
      end
    end
    check("shift_cycles", cyc, 11 + stall_len);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    check("frame_cnt_after", frame_cnt, exp_cnt);
    gap = 0;
    while (!msg_ready && gap < 50) begin
      check("tx_valid_gap", tx_valid, 1'b0);
      gap++;
      @(negedge clk);
    end
    check("gap_len", gap, G);
    $display("frame msg=%02h err_pos=%0d shift_cycles=%0d gap=%0d frame_cnt=%0d",
             m, e, cyc, gap, frame_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    repeat (2) @(negedge clk);
    check("rst_msg_ready", msg_ready, 1'b1);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_bit", tx_bit, 1'b0);
    check("rst_tx_first", tx_first, 1'b0);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_cnt0", frame_cnt0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mid-frame reset at beat 6 of msg 0x01
    msg_valid = 1'b1; msg = 7'h01; err_pos = '0; tx_ready = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      @(negedge clk);
      msg_valid = 1'b0;
      check($sformatf("abort_tx_first[%0d]", b), tx_first, b == 1);
    end
    rst_n = 1'b0;
    #1;
    check("abort_msg_ready", msg_ready, 1'b1);
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_tx_bit", tx_bit, 1'b0);
    check("abort_tx_first", tx_first, 1'b0);
    check("abort_tx_last", tx_last, 1'b0);
    check("abort_frame_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("frame msg=01 aborted by reset at beat 6");
    @(negedge clk);
    check("post_abort_idle", msg_ready, 1'b1);
    check("post_abort_tx_valid", tx_valid, 1'b0);

    send_frame(7'h01, 4'd0,  11'b11100000000, 0, 0);
    send_frame(7'h08, 4'd0,  11'b11010010000, 0, 0);
    send_frame(7'h7F, 4'd0,  11'b11111111111, 0, 0);
    send_frame(7'h00, 4'd3,  11'b00100000000, 0, 0);
    send_frame(7'h00, 4'd13, 11'b00000000000, 0, 0);
    send_frame(7'h55, 4'd11, 11'b11110100100, 0, 0);
    send_frame(7'h7F, 4'd1,  11'b01111111111, 0, 0);
    send_frame(7'h01, 4'd0,  11'b11100000000, 2, 3);

    // Back-to-back frames with GAP_CYCLES=0: one accept every 12 cycles, counter wraps.
    accepts = 0;
    msg_valid0 = 1'b1;
    for (int c = 0; c <= 12 * 256; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("b2b_ready[%0d]", c), msg_ready0, (c % 12) == 0);
      if (msg_ready0) accepts++;
      if (c == 1) begin
        check("b2b_first", tx_first0, 1'b1);
        check("b2b_bit1", tx_bit0, 1'b1);
      end
      if (c == 11) check("b2b_last", tx_last0, 1'b1);
      if (c == 12) begin
        check("b2b_cnt1", frame_cnt0, 1);
        check("b2b_tx_valid_idle", tx_valid0, 1'b0);
      end
      if (c == 12 * 255) check("b2b_cnt255", frame_cnt0, 255);
      if (c == 12 * 256) begin
        check("b2b_cnt_wrap", frame_cnt0, 0);
        msg_valid0 = 1'b0;
      end
    end
    check("b2b_accepts", accepts, 257);
    $display("back-to-back run: %0d accepts, frame_cnt0=%0d", accepts, frame_cnt0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
